lcd_char_ctrl: RTL and testbench

- Write-only controller for the DE2-115 16x2 HD44780-compatible character LCD.
- Runs the power-on init sequence.
- Then accepts byte writes (command or character) over a valid/ready handshake and sequences RS/DATA/EN with the required setup, enable, hold and execution delays.
- Instantiated in the board top level. Its outputs drive LCD_DATA/LCD_EN/LCD_RS/LCD_ON/LCD_BLON. RW is not brought out; the top ties it to write.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_char_ctrl.sv | 143 ++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD controller:
// FSM state encoding, the power-on init byte table and the long-command test.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } state_t;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

  localparam int INIT_LEN = 6;

  // Entry 0 is sent first; function-set is repeated to force 8-bit mode from any power-up state.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    CMD_ENTRY_INC, CMD_CLEAR, CMD_DISP_ON,
    CMD_FUNC_8B2L, CMD_FUNC_8B2L, CMD_FUNC_8B2L
  };

  // Clear and return-home take ~1.5 ms in the controller; all other bytes finish in ~40 us.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_char_ctrl.sv
// Write-only HD44780 LCD sequencer: power-on init, then one byte per accepted valid/ready write.
// Latency: byte on the pins the cycle after accept; o_ready drops until setup+EN+hold+execution wait expire.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 4,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 4,
  parameter int T_CMD   = 2500,
  parameter int T_CLR   = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_lcd_blon
);

  localparam int T_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int IDX_W = $clog2(INIT_LEN);

  localparam logic [CNT_W-1:0] C_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] C_CLR   = CNT_W'(T_CLR - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_rs, w_rs_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_idx_inc  = r_idx + IDX_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_PWRUP;
      r_cnt       <= C_PWRUP;
      r_idx       <= '0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_data      <= w_data_nxt;
      r_rs        <= w_rs_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // The byte fetch (init table or user byte) happens on the transition into SETUP.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
    w_idx_nxt       = r_idx;
    w_data_nxt      = r_data;
    w_rs_nxt        = r_rs;
    w_init_done_nxt = r_init_done;
    case (r_state)
      ST_PWRUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = C_SETUP;
          w_data_nxt  = INIT_ROM[r_idx];
          w_rs_nxt    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_EN_HI;
          w_cnt_nxt   = C_EN;
        end
      end
      ST_EN_HI: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = C_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = is_long_cmd(r_rs, r_data) ? C_CLR : C_CMD;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          if (r_init_done) begin
            w_state_nxt = ST_IDLE;
          end else if (r_idx == IDX_LAST) begin
            w_state_nxt     = ST_IDLE;
            w_init_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = C_SETUP;
            w_idx_nxt   = w_idx_inc;
            w_data_nxt  = INIT_ROM[w_idx_inc];
            w_rs_nxt    = 1'b0;
          end
        end
      end
      ST_IDLE: begin
        if (i_valid) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = C_SETUP;
          w_data_nxt  = i_data;
          w_rs_nxt    = i_rs;
        end
      end
      default: begin
        w_state_nxt = ST_PWRUP;
        w_cnt_nxt   = C_PWRUP;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign o_ready     = (r_state == ST_IDLE);
  assign o_init_done = r_init_done;
  assign o_lcd_data  = r_data;
  assign o_lcd_rs    = r_rs;
  assign o_lcd_en    = (r_state == ST_EN_HI);
  assign o_lcd_on    = 1'b1;
  assign o_lcd_blon  = 1'b1;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: a timeline model (byte start/end cycles) checked every cycle,
// plus literal expectations for init timing, write latencies, streaming and mid-operation reset.
module tb_lcd_char_ctrl;

  localparam int TP = 100;
  localparam int TS = 2;
  localparam int TE = 4;
  localparam int TH = 2;
  localparam int TC = 10;
  localparam int TL = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_init_done, o_lcd_rs, o_lcd_en, o_lcd_on, o_lcd_blon;
  logic [7:0] o_lcd_data;

  lcd_char_ctrl #(
    .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLR(TL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_rs(i_rs), .i_data(i_data),
    .o_ready(o_ready), .o_init_done(o_init_done), .o_lcd_data(o_lcd_data),
    .o_lcd_rs(o_lcd_rs), .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_lcd_blon(o_lcd_blon)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_c = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_c);
    end
  endtask

  // Cycle number since the last reset release; cycle 0 is the first cycle with rst_n high.
  always @(posedge clk) begin
    if (!rst_n) m_c = 0;
    else        m_c = m_c + 1;
  end

  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         m_start, m_end, m_idx, n_accept = 0;
  logic [7:0] m_data;
  logic       m_rs, m_done, m_armed = 1'b0;
  logic       e_en, e_rdy, prev_en, prev_done;
  int         rise_cyc [$];
  logic [8:0] rise_dat [$];
  int         done_cyc = -1;

  function automatic int dur(input logic r, input logic [7:0] d);
    return TS + TE + TH + ((!r && d >= 8'h01 && d <= 8'h03) ? TL : TC);
  endfunction

  function automatic void launch(input logic r, input logic [7:0] d, input int s);
    m_rs = r;
    m_data = d;
    m_start = s;
    m_end = s + dur(r, d);
  endfunction

  always @(negedge clk) begin
    if (m_armed) begin
      if (!m_done && m_c == m_end) begin
        if (m_idx == 5) m_done = 1'b1;
        else begin
          m_idx++;
          launch(1'b0, rom[m_idx], m_c);
        end
      end
      e_en  = (m_c >= m_start + TS) && (m_c < m_start + TS + TE);
      e_rdy = m_done && (m_c >= m_end);
      check("lcd_en", o_lcd_en, e_en);
      check("ready", o_ready, e_rdy);
      check("init_done", o_init_done, m_done);
      check("lcd_data", o_lcd_data, m_data);
      check("lcd_rs", o_lcd_rs, m_rs);
      check("lcd_on", o_lcd_on, 1'b1);
      check("lcd_blon", o_lcd_blon, 1'b1);
      if (rst_n && e_rdy && i_valid) begin
        launch(i_rs, i_data, m_c + 1);
        n_accept++;
      end
      if (o_lcd_en === 1'b1 && !prev_en) begin
        rise_cyc.push_back(m_c);
        rise_dat.push_back({o_lcd_rs, o_lcd_data});
      end
      if (o_init_done === 1'b1 && !prev_done) done_cyc = m_c;
      prev_en = (o_lcd_en === 1'b1);
      prev_done = (o_init_done === 1'b1);
    end
    if (!rst_n) begin
      m_armed = 1'b1;
      m_idx = -1;
      m_end = TP;
      m_start = 1 << 30;
      m_data = 8'h00;
      m_rs = 1'b0;
      m_done = 1'b0;
      prev_en = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_ready(output int t);
    int n = 0;
    t = -1;
    while (t < 0 && n < 500) begin
      @(negedge clk); #1;
      if (o_ready === 1'b1) t = m_c;
      n++;
    end
    check("ready_timeout", (t >= 0), 1'b1);
  endtask

  task automatic do_write(input logic r, input logic [7:0] d, output int t_acc);
    int n = 0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_rs = r; i_data = d;
    t_acc = -1;
    while (t_acc < 0 && n < 500) begin
      @(negedge clk); #1;
      if (o_ready === 1'b1) t_acc = m_c;
      n++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_rs = ~r; i_data = ~d;
    check("accept_timeout", (t_acc >= 0), 1'b1);
  endtask

  logic [8:0] init_exp [6] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};

  task automatic check_init_log(input int t_rdy);
    check("init_pulses", rise_cyc.size(), 6);
    if (rise_cyc.size() > 0) check("first_en_cycle", rise_cyc[0], 102);
    for (int i = 0; i < 6; i++)
      if (i < rise_dat.size()) check("init_byte", rise_dat[i], init_exp[i]);
    check("init_done_cycle", done_cyc, 238);
    check("init_ready_cycle", t_rdy, 238);
  endtask

  typedef struct { logic r; logic [7:0] d; int lat; } wr_t;
  wr_t wr_tab [6] = '{
    '{1'b1, 8'h41, 19}, '{1'b0, 8'h01, 49}, '{1'b1, 8'h01, 19},
    '{1'b0, 8'h03, 49}, '{1'b0, 8'h04, 19}, '{1'b0, 8'h02, 49}
  };

  initial begin
    int t, t2, acc0, en0, n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 i_valid = 1'b1; i_data = 8'h77;
    repeat (2) @(posedge clk);
    #1 i_valid = 1'b0;
    wait_ready(t);
    check_init_log(t);

    for (int k = 0; k < 6; k++) begin
      do_write(wr_tab[k].r, wr_tab[k].d, t);
      wait_ready(t2);
      check("write_latency", t2 - t, wr_tab[k].lat);
      if (rise_cyc.size() > 0) check("write_en_cycle", rise_cyc[$], t + 3);
      if (rise_dat.size() > 0) check("write_byte", rise_dat[$], {wr_tab[k].r, wr_tab[k].d});
    end

    acc0 = n_accept;
    en0 = rise_cyc.size();
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_data = 8'(8'h50 + i);
      i_rs = i[0];
    end
    @(posedge clk); #1 i_valid = 1'b0;
    wait_ready(t);
    check("stream_accepts", n_accept - acc0, 4);
    check("stream_en_pulses", rise_cyc.size() - en0, n_accept - acc0);

    do_write(1'b1, 8'h55, t);
    n = 0;
    while (o_lcd_en !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("en_seen", o_lcd_en, 1'b1);
    @(posedge clk); #1 i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0; rst_n = 1'b0;
    rise_cyc.delete();
    rise_dat.delete();
    done_cyc = -1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_en", o_lcd_en, 1'b0);
    check("rst_ready", o_ready, 1'b0);
    check("rst_done", o_init_done, 1'b0);
    check("rst_data", o_lcd_data, 8'h00);
    repeat (20) @(posedge clk);
    #1 i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1 i_valid = 1'b0;
    wait_ready(t);
    check_init_log(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
